neuron_operand_loader: RTL and testbench
========================================

Name: neuron_operand_loader

Overview:
- Upstream stage of the 4-input neuron datapath.
- Accepts a serial stream of signed 8-bit activations over a valid/ready handshake and assembles groups of four into an X1..X4 vector.
- Holds a config shadow bank: W1..W4, bias, xmin, xmax.
- Presents each complete operand bundle to the neuron through a registered, double-buffered valid/ready output, so weights and bias stay coherent per vector.

Parameters:
- DATA_W, 8, width of activations and weights.
- BIAS_W, 16, width of bias.
- CLAMP_W, 12, width of xmin/xmax clamp bounds.
- XMIN_RST, -128, reset value of the xmin shadow and output.
- XMAX_RST, 127, reset value of the xmax shadow and output.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- soft_clr  in  1  synchronous clear of the vector pipeline; config is kept.
- in_data  in  DATA_W  signed activation sample.
- in_valid  in  1  sample valid.
- in_ready  out  1  loader can accept a sample.
- cfg_we  in  1  config write strobe.
- cfg_sel  in  3  target select: 0-3 = W1-W4, 4 = bias, 5 = xmin, 6 = xmax, 7 = ignored.
- cfg_data  in  BIAS_W  write data; low DATA_W or CLAMP_W bits are used for narrower targets.
- X1..X4  out  DATA_W each  signed activation vector, X1 = first sample of the group.
- W1..W4  out  DATA_W each  signed weights latched with the vector.
- bias  out  BIAS_W  signed bias latched with the vector.
- xmin, xmax  out  CLAMP_W each  clamp bounds latched with the vector.
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  neuron stage accepts the bundle.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - X*, W*, bias = 0; xmin = XMIN_RST; xmax = XMAX_RST.
  - out_valid = 0, in_ready = 1.
  - Element counter cnt = 0, asm_full = 0.
  - Shadows reset to the same values as the outputs.
- Sample acceptance:
  - A sample is accepted when in_valid && in_ready.
  - It is written to assembly slot cnt; cnt increments 0→1→2→3.
  - in_ready = !asm_full. It is a registered-state function, with no combinational path from in_valid or out_ready.
- Fourth accept (cnt == 3):
  - cnt wraps to 0.
  - If the output slot is free (!out_valid || out_ready) in the same cycle: output registers load {slot0, slot1, slot2, in_data} plus all shadows, and out_valid = 1 next cycle. Latency is 1 cycle from the 4th accept.
  - Otherwise asm_full = 1 and the vector is held.
- asm_full = 1 and out_valid && out_ready: output loads from the assembly buffer and shadows, out_valid stays 1, asm_full = 0.
- out_valid && out_ready with nothing pending: out_valid = 0 next cycle. Outputs hold their last values.
- Output stability: while out_valid && !out_ready, every output bit is stable.
- Sustained throughput: one bundle per 4 input cycles. The input never stalls if out_ready stays high.
- Config writes:
  - A write updates the shadow only, taking effect at the next bundle load.
  - A write in the same cycle as a load is visible in that load (write-first).
  - cfg_sel = 7 has no effect.
  - Writes are always accepted, regardless of the handshake state.
- Truncation:
  - cfg_data[DATA_W-1:0] goes to W registers.
  - cfg_data[CLAMP_W-1:0] goes to xmin/xmax.
  - No range check; a bench-set xmin > xmax is passed through unchanged.
- soft_clr:
  - Highest synchronous priority: cnt = 0, asm_full = 0, out_valid = 0.
  - Partial vectors are discarded.
  - Samples presented in the same cycle are dropped.
  - Shadows are untouched.
- Reset mid-vector discards the partial vector and any pending bundle; no output pulse follows.

Decomposition:
- Shared package neuron_pkg: DATA_W, BIAS_W, CLAMP_W, XMIN_RST, XMAX_RST, the cfg_sel encodings (CFG_W1..CFG_W4, CFG_BIAS, CFG_XMIN, CFG_XMAX), and a packed operand-bundle typedef.
- One sub-module is natural: neuron_cfg_bank, which holds the shadow registers, write decode and reset values.
- Assembly, counter and handshake logic stay in the top module.

Test Plan:
- Reset, then write W = {2, -3, 4, 1}, bias = 100, and stream 10, 20, -5, 7 with out_ready = 1 → out_valid rises 1 cycle after the 4th accept with X = {10, 20, -5, 7}, W = {2, -3, 4, 1}, bias = 100, xmin = -128, xmax = 127.
- Backpressure: hold out_ready = 0 and stream 8 samples → first bundle held stable, second group fills asm_full, in_ready drops after the 8th accept; raising out_ready for 1 cycle loads the second bundle with out_valid staying 1 and in_ready returning to 1.
- Config coherence: write W1 = 5 mid-group, after sample 2 → the bundle issued at this group's 4th sample carries W1 = 5, and the previous held bundle still shows the old W1.
- soft_clr after 2 samples, then stream 1, 2, 3, 4 → single bundle X = {1, 2, 3, 4}, with the earlier partial samples absent.
- Async reset asserted mid-bundle while out_valid = 1 → out_valid = 0 immediately, X = 0, xmin = -128, xmax = 127, in_ready = 1.
- Continuous stream of 16 samples with out_ready = 1 → exactly 4 bundles, each 4 cycles apart, in_ready never deasserts.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and constants for the 4-input neuron datapath: widths, reset
// bounds, config-select encodings and the operand bundle layout.
package neuron_pkg;

  localparam int DATA_W   = 8;
  localparam int BIAS_W   = 16;
  localparam int CLAMP_W  = 12;
  localparam int XMIN_RST = -128;
  localparam int XMAX_RST = 127;

  typedef enum logic [2:0] {
    CFG_W1   = 3'd0,
    CFG_W2   = 3'd1,
    CFG_W3   = 3'd2,
    CFG_W4   = 3'd3,
    CFG_BIAS = 3'd4,
    CFG_XMIN = 3'd5,
    CFG_XMAX = 3'd6,
    CFG_NONE = 3'd7
  } cfg_sel_e;

  typedef struct packed {
    logic [3:0][DATA_W-1:0] w;     // w[0] = W1
    logic [BIAS_W-1:0]      bias;
    logic [CLAMP_W-1:0]     xmin;
    logic [CLAMP_W-1:0]     xmax;
  } cfg_t;

  typedef struct packed {
    logic [3:0][DATA_W-1:0] x;     // x[0] = X1, the first sample of the group
    cfg_t                   cfg;
  } operand_bundle_t;

  function automatic cfg_t cfg_reset();
    cfg_t r;
    r      = '0;
    r.xmin = CLAMP_W'(XMIN_RST);
    r.xmax = CLAMP_W'(XMAX_RST);
    return r;
  endfunction

endpackage

// File: rtl/neuron_cfg_bank.sv
// Config shadow bank: W1..W4, bias, xmin, xmax. Exposes the post-write view so
// a bundle loaded in the same cycle as a write sees the new value.
module neuron_cfg_bank
  import neuron_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_sel,
  input  logic [BIAS_W-1:0] cfg_data,
  output cfg_t              o_cfg_next
);

  cfg_t r_cfg;
  cfg_t w_cfg_next;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_cfg_next = r_cfg;
    if (cfg_we) begin
      case (cfg_sel_e'(cfg_sel))
        CFG_W1:   w_cfg_next.w[0] = cfg_data[DATA_W-1:0];
        CFG_W2:   w_cfg_next.w[1] = cfg_data[DATA_W-1:0];
        CFG_W3:   w_cfg_next.w[2] = cfg_data[DATA_W-1:0];
        CFG_W4:   w_cfg_next.w[3] = cfg_data[DATA_W-1:0];
        CFG_BIAS: w_cfg_next.bias = cfg_data;
        CFG_XMIN: w_cfg_next.xmin = cfg_data[CLAMP_W-1:0];
        CFG_XMAX: w_cfg_next.xmax = cfg_data[CLAMP_W-1:0];
        default:  ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cfg <= cfg_reset();
    else        r_cfg <= w_cfg_next;
  end

  assign o_cfg_next = w_cfg_next;

endmodule

// File: rtl/neuron_operand_loader.sv
// Assembles serial activations into 4-element vectors and presents them with a
// coherent config snapshot through a registered, double-buffered output.
module neuron_operand_loader
  import neuron_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      soft_clr,
  input  logic signed [DATA_W-1:0]  in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      cfg_we,
  input  logic [2:0]                cfg_sel,
  input  logic [BIAS_W-1:0]         cfg_data,
  output logic signed [DATA_W-1:0]  X1,
  output logic signed [DATA_W-1:0]  X2,
  output logic signed [DATA_W-1:0]  X3,
  output logic signed [DATA_W-1:0]  X4,
  output logic signed [DATA_W-1:0]  W1,
  output logic signed [DATA_W-1:0]  W2,
  output logic signed [DATA_W-1:0]  W3,
  output logic signed [DATA_W-1:0]  W4,
  output logic signed [BIAS_W-1:0]  bias,
  output logic signed [CLAMP_W-1:0] xmin,
  output logic signed [CLAMP_W-1:0] xmax,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [1:0]        r_cnt;
  logic              r_asm_full;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_asm [4];
  operand_bundle_t   r_out;

  cfg_t            w_cfg;
  logic            w_accept;
  logic            w_fourth;
  logic            w_slot_free;
  logic            w_load_in;
  logic            w_load_asm;
  logic            w_load;
  operand_bundle_t w_bundle;

  neuron_cfg_bank u_cfg_bank (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_data   (cfg_data),
    .o_cfg_next (w_cfg)
  );

  assign in_ready    = !r_asm_full;
  assign w_accept    = in_valid && in_ready && !soft_clr;
  assign w_fourth    = w_accept && (r_cnt == 2'd3);
  assign w_slot_free = !r_out_valid || out_ready;
  // A held vector blocks new samples, so the two load sources never coincide.
  assign w_load_in   = w_fourth && w_slot_free;
  assign w_load_asm  = r_asm_full && r_out_valid && out_ready && !soft_clr;

  always_comb begin
    w_load   = 1'b0;
    w_bundle = r_out;
    if (w_load_in) begin
      w_load       = 1'b1;
      w_bundle.x   = {in_data, r_asm[2], r_asm[1], r_asm[0]};
      w_bundle.cfg = w_cfg;
    end else if (w_load_asm) begin
      w_load       = 1'b1;
      w_bundle.x   = {r_asm[3], r_asm[2], r_asm[1], r_asm[0]};
      w_bundle.cfg = w_cfg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt          <= 2'd0;
      r_asm_full     <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out.x        <= '0;
      r_out.cfg      <= cfg_reset();
    end else if (soft_clr) begin
      r_cnt       <= 2'd0;
      r_asm_full  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) r_cnt <= 2'(r_cnt + 2'd1);
      if (w_fourth && !w_slot_free) r_asm_full <= 1'b1;
      else if (w_load_asm)          r_asm_full <= 1'b0;
      if (w_load) begin
        r_out       <= w_bundle;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // NOTE: the assembly slots carry no reset; each is written before any load
  // can read it, so resetting them would only add reset fanout.
  always_ff @(posedge clk) begin
    if (w_accept) r_asm[r_cnt] <= in_data;
  end

  assign X1        = r_out.x[0];
  assign X2        = r_out.x[1];
  assign X3        = r_out.x[2];
  assign X4        = r_out.x[3];
  assign W1        = r_out.cfg.w[0];
  assign W2        = r_out.cfg.w[1];
  assign W3        = r_out.cfg.w[2];
  assign W4        = r_out.cfg.w[3];
  assign bias      = r_out.cfg.bias;
  assign xmin      = r_out.cfg.xmin;
  assign xmax      = r_out.cfg.xmax;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_neuron_operand_loader.sv
// Self-checking bench: queue-level reference model compared every cycle, plus
// directed scenarios with hand-computed expectations and a randomized phase.
module tb_neuron_operand_loader;
  import neuron_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic soft_clr = 1'b0;
  logic signed [DATA_W-1:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic cfg_we = 1'b0;
  logic [2:0] cfg_sel = 3'd7;
  logic [BIAS_W-1:0] cfg_data = '0;
  logic signed [DATA_W-1:0] X1, X2, X3, X4, W1, W2, W3, W4;
  logic signed [BIAS_W-1:0] bias;
  logic signed [CLAMP_W-1:0] xmin, xmax;
  logic out_valid;
  logic out_ready = 1'b1;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;
  int cyc    = 0;
  int fire_q[$];
  int ready_low = 0;
  bit mon_en = 1'b0;

  neuron_operand_loader dut (
    .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .X1(X1), .X2(X2), .X3(X3), .X4(X4),
    .W1(W1), .W2(W2), .W3(W3), .W4(W4),
    .bias(bias), .xmin(xmin), .xmax(xmax),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a partial group, a queue of completed vectors waiting for
  // the output slot, and the currently presented bundle.
  logic signed [DATA_W-1:0]  s_w [4];
  logic signed [BIAS_W-1:0]  s_bias;
  logic signed [CLAMP_W-1:0] s_xmin, s_xmax;
  logic signed [DATA_W-1:0]  m_x [4];
  logic signed [DATA_W-1:0]  m_w [4];
  logic signed [BIAS_W-1:0]  m_bias;
  logic signed [CLAMP_W-1:0] m_xmin, m_xmax;
  bit m_valid;
  logic [DATA_W-1:0] part_q[$];
  logic [4*DATA_W-1:0] pend_q[$];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin s_w[i] = '0; m_w[i] = '0; m_x[i] = '0; end
    s_bias = '0; m_bias = '0;
    s_xmin = CLAMP_W'(XMIN_RST); m_xmin = s_xmin;
    s_xmax = CLAMP_W'(XMAX_RST); m_xmax = s_xmax;
    m_valid = 1'b0;
    part_q.delete();
    pend_q.delete();
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      bit can_take;
      logic [4*DATA_W-1:0] v;
      can_take = (pend_q.size() == 0);
      if (cfg_we) begin
        if (cfg_sel < 3'd4)       s_w[cfg_sel] = cfg_data[DATA_W-1:0];
        else if (cfg_sel == 3'd4) s_bias = cfg_data;
        else if (cfg_sel == 3'd5) s_xmin = cfg_data[CLAMP_W-1:0];
        else if (cfg_sel == 3'd6) s_xmax = cfg_data[CLAMP_W-1:0];
      end
      if (soft_clr) begin
        part_q.delete();
        pend_q.delete();
        m_valid = 1'b0;
      end else begin
        if (m_valid && out_ready) m_valid = 1'b0;
        if (in_valid && can_take) begin
          part_q.push_back(in_data);
          if (part_q.size() == 4) begin
            pend_q.push_back({part_q[3], part_q[2], part_q[1], part_q[0]});
            part_q.delete();
          end
        end
        if (!m_valid && pend_q.size() > 0) begin
          v = pend_q.pop_front();
          for (int i = 0; i < 4; i++) begin
            m_x[i] = v[i*DATA_W +: DATA_W];
            m_w[i] = s_w[i];
          end
          m_bias = s_bias; m_xmin = s_xmin; m_xmax = s_xmax;
          m_valid = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", int'(out_valid), int'(m_valid));
      check("in_ready", int'(in_ready), int'(pend_q.size() == 0));
      check("X1", X1, m_x[0]); check("X2", X2, m_x[1]);
      check("X3", X3, m_x[2]); check("X4", X4, m_x[3]);
      check("W1", W1, m_w[0]); check("W2", W2, m_w[1]);
      check("W3", W3, m_w[2]); check("W4", W4, m_w[3]);
      check("bias", bias, m_bias);
      check("xmin", xmin, m_xmin); check("xmax", xmax, m_xmax);
    end
    if (mon_en) begin
      if (out_valid && out_ready) fire_q.push_back(cyc);
      if (!in_ready) ready_low++;
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  // in_ready is read only to pace the stimulus, never as an expectation.
  task automatic send(input logic [DATA_W-1:0] d);
    bit done;
    done = 1'b0;
    in_data = d; in_valid = 1'b1;
    for (int t = 0; t < 64 && !done; t++) begin
      done = in_ready;
      @(posedge clk); @(negedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic cfg(input logic [2:0] sel, input logic [BIAS_W-1:0] d);
    cfg_we = 1'b1; cfg_sel = sel; cfg_data = d;
    step();
    cfg_we = 1'b0; cfg_sel = 3'd7;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_xmin", xmin, -128);
    check("rst_xmax", xmax, 127);
    chk_en = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Basic bundle with literal expectations.
    cfg(3'd0, 16'd2); cfg(3'd1, 16'hFFFD); cfg(3'd2, 16'd4); cfg(3'd3, 16'd1);
    cfg(3'd4, 16'd100);
    send(8'd10); send(8'd20); send(8'hFB); send(8'd7);
    check("t1_valid", int'(out_valid), 1);
    check("t1_X1", X1, 10); check("t1_X2", X2, 20);
    check("t1_X3", X3, -5); check("t1_X4", X4, 7);
    check("t1_W1", W1, 2); check("t1_W2", W2, -3);
    check("t1_W3", W3, 4); check("t1_W4", W4, 1);
    check("t1_bias", bias, 100);
    check("t1_xmin", xmin, -128); check("t1_xmax", xmax, 127);
    step();

    // Backpressure with a mid-group W1 update.
    out_ready = 1'b0;
    send(8'd11); send(8'd12); send(8'd13); send(8'd14);
    send(8'd21); send(8'd22);
    cfg(3'd0, 16'd5);
    send(8'd23); send(8'd24);
    repeat (3) step();
    check("bp_valid", int'(out_valid), 1);
    check("bp_held_X1", X1, 11);
    check("bp_held_W1", W1, 2);
    check("bp_in_ready", int'(in_ready), 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_valid2", int'(out_valid), 1);
    check("bp_X1", X1, 21); check("bp_X4", X4, 24);
    check("bp_W1", W1, 5);
    check("bp_in_ready2", int'(in_ready), 1);
    out_ready = 1'b1;
    repeat (2) step();

    // soft_clr discards a partial group and a same-cycle sample.
    fire_q.delete(); mon_en = 1'b1;
    send(8'd50); send(8'd51);
    soft_clr = 1'b1; in_valid = 1'b1; in_data = 8'd99;
    step();
    soft_clr = 1'b0; in_valid = 1'b0;
    send(8'd1); send(8'd2); send(8'd3); send(8'd4);
    check("sc_X1", X1, 1); check("sc_X2", X2, 2);
    check("sc_X3", X3, 3); check("sc_X4", X4, 4);
    repeat (2) step();
    mon_en = 1'b0;
    check("sc_bundles", fire_q.size(), 1);

    // Continuous 16-sample stream.
    fire_q.delete(); ready_low = 0; mon_en = 1'b1;
    for (int i = 0; i < 16; i++) send(8'(i + 100));
    repeat (2) step();
    mon_en = 1'b0;
    check("st_bundles", fire_q.size(), 4);
    for (int i = 1; i < fire_q.size(); i++) check("st_spacing", fire_q[i] - fire_q[i-1], 4);
    check("st_ready_low", ready_low, 0);

    // Async reset while a bundle is held.
    out_ready = 1'b0;
    send(8'd31); send(8'd32); send(8'd33); send(8'd34);
    send(8'd41);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", int'(out_valid), 0);
    check("ar_X1", X1, 0);
    check("ar_xmin", xmin, -128); check("ar_xmax", xmax, 127);
    check("ar_in_ready", int'(in_ready), 1);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) step();
    check("ar_no_pulse", int'(out_valid), 0);

    // Randomized traffic, including out-of-order clamp bounds.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      cfg_we    = ($urandom_range(0, 7) == 0);
      cfg_sel   = 3'($urandom_range(0, 7));
      cfg_data  = 16'($urandom);
      soft_clr  = ($urandom_range(0, 99) == 0);
      step();
    end
    in_valid = 1'b0; cfg_we = 1'b0; soft_clr = 1'b0; out_ready = 1'b1;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
